// File: rtl/ascon_output_ctrl.sv
// AEAD128 output-stream sequencer: counts data blocks for a message, then the tag block,
// and steers the truncation stage on the final partial data block. Handshake is pass-through.
module ascon_output_ctrl #(
    parameter int LEN_W       = 16,
    parameter int BLOCK_BYTES = 16,
    parameter int PAD_AW      = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              trunc_en_o,
    output logic [PAD_AW-1:0] trunc_idx_o,
    output logic              tag_o,
    output logic              last_o,
    output logic              done_o
);

    // One bit wider than len_i[LEN_W-1:PAD_AW] so a maximum-length message cannot overflow.
    localparam int CNT_W = LEN_W - PAD_AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAG  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   nblk_q, nblk_d;
    logic [PAD_AW-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]   nblk_start;
    logic               xfer;

    assign nblk_start = CNT_W'(len_i[LEN_W-1:PAD_AW]) + CNT_W'(|len_i[PAD_AW-1:0]);
    assign xfer       = blk_valid_i & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            nblk_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            nblk_q  <= nblk_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        nblk_d      = nblk_q;
        rem_d       = rem_q;
        busy_o      = 1'b0;
        blk_ready_o = 1'b0;
        out_valid_o = 1'b0;
        trunc_en_o  = 1'b0;
        trunc_idx_o = '0;
        tag_o       = 1'b0;
        last_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    nblk_d  = nblk_start;
                    rem_d   = len_i[PAD_AW-1:0];
                    state_d = (nblk_start != '0) ? DATA : TAG;
                end
            end
            DATA: begin
                busy_o      = 1'b1;
                blk_ready_o = out_ready_i;
                out_valid_o = blk_valid_i;
                if ((nblk_q == CNT_W'(1)) && (rem_q != '0)) begin
                    trunc_en_o  = 1'b1;
                    trunc_idx_o = rem_q;
                end
                if (xfer) begin
                    nblk_d = nblk_q - CNT_W'(1);
                    if (nblk_q == CNT_W'(1)) begin
                        state_d = TAG;
                    end
                end
            end
            TAG: begin
                busy_o      = 1'b1;
                blk_ready_o = out_ready_i;
                out_valid_o = blk_valid_i;
                tag_o       = 1'b1;
                last_o      = 1'b1;
                if (xfer) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_output_ctrl.sv
// Scoreboard bench for ascon_output_ctrl: directed messages push expected per-transfer
// control words; a negedge monitor pops and compares on every accepted output block.
module tb_ascon_output_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        blk_valid_i;
    logic        blk_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        trunc_en_o;
    logic [3:0]  trunc_idx_o;
    logic        tag_o;
    logic        last_o;
    logic        done_o;

    typedef struct packed {
        logic       tag;
        logic       last;
        logic       ten;
        logic [3:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   done_cnt = 0;

    ascon_output_ctrl #(.LEN_W(16), .BLOCK_BYTES(16), .PAD_AW(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .blk_valid_i (blk_valid_i),
        .blk_ready_o (blk_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .trunc_en_o  (trunc_en_o),
        .trunc_idx_o (trunc_idx_o),
        .tag_o       (tag_o),
        .last_o      (last_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: one line per accepted block, plus the ready pass-through check.
    always @(negedge clk_i) begin
        if (!rst_i && done_o) done_cnt++;
        if (!rst_i && out_valid_o) begin
            tests++;
            if (blk_ready_o !== out_ready_i) begin
                fails++;
                $display("FAIL ready_mirror: got %0b, expected %0b", blk_ready_o, out_ready_i);
            end
        end
        if (!rst_i && out_valid_o && out_ready_i) begin
            automatic exp_t got = '{tag: tag_o, last: last_o, ten: trunc_en_o, idx: trunc_idx_o};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_xfer: got tag=%0b last=%0b ten=%0b idx=%0d, expected no transfer",
                         got.tag, got.last, got.ten, got.idx);
            end else begin
                automatic exp_t e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL xfer: got tag=%0b last=%0b ten=%0b idx=%0d, expected tag=%0b last=%0b ten=%0b idx=%0d",
                             got.tag, got.last, got.ten, got.idx, e.tag, e.last, e.ten, e.idx);
                end else if (!(e.tag == 0 && e.ten == 0 && exp_q.size() > 64)) begin
                    $display("[TB] xfer tag=%0b last=%0b ten=%0b idx=%0d ok", got.tag, got.last, got.ten, got.idx);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic tag, input logic last, input logic ten, input logic [3:0] idx);
        exp_q.push_back('{tag: tag, last: last, ten: ten, idx: idx});
    endtask

    task automatic start_msg(input int len);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        len_i   = 16'(len);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        len_i   = '0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk_i); #1;
            if (toggle) out_ready_i = ~out_ready_i;
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: got no done_o, expected done_o within %0d cycles", name, budget);
        end
    endtask

    task automatic end_msg(input string name, input int d0);
        repeat (3) @(negedge clk_i);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_busy_idle"}, int'(busy_o), 0);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        $display("[TB] message %s complete", name);
    endtask

    initial begin
        int d0;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        len_i       = '0;
        blk_valid_i = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        blk_valid_i = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_blk_ready", int'(blk_ready_o), 0);
        chk("rst_tag_last", int'({tag_o, last_o}), 0);
        chk("rst_trunc", int'({trunc_en_o, trunc_idx_o}), 0);
        chk("rst_done", int'(done_o), 0);

        // len=0: tag only, busy falls the cycle after done
        d0 = done_cnt;
        push(1, 1, 0, 0);
        start_msg(0);
        wait_done(20, 0, "len0");
        chk("len0_busy_at_done", int'(busy_o), 1);
        @(negedge clk_i);
        chk("len0_busy_after_done", int'(busy_o), 0);
        chk("len0_done_one_cycle", int'(done_o), 0);
        end_msg("len0", d0);

        // len=16: one full block, then tag
        d0 = done_cnt;
        push(0, 0, 0, 0);
        push(1, 1, 0, 0);
        start_msg(16);
        wait_done(20, 0, "len16");
        end_msg("len16", d0);

        // len=35: two full blocks, final block of 3 bytes
        d0 = done_cnt;
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        push(0, 0, 1, 3);
        push(1, 1, 0, 0);
        start_msg(35);
        wait_done(20, 0, "len35");
        end_msg("len35", d0);

        // len=32 with a sink toggling ready every cycle
        d0 = done_cnt;
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        push(1, 1, 0, 0);
        start_msg(32);
        wait_done(40, 1, "len32_stall");
        out_ready_i = 1'b1;
        end_msg("len32_stall", d0);

        // len=48 with a stray start (len=5) during DATA
        d0 = done_cnt;
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        push(1, 1, 0, 0);
        start_msg(48);
        start_i = 1'b1;
        len_i   = 16'd5;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        len_i   = '0;
        wait_done(20, 0, "len48");
        end_msg("len48", d0);

        // len=64, reset after the first data transfer
        d0 = done_cnt;
        push(0, 0, 0, 0);
        start_msg(64);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_out_valid", int'(out_valid_o), 0);
        chk("abort_done", int'(done_o), 0);
        repeat (3) @(negedge clk_i);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_queue_empty", exp_q.size(), 0);

        // len=1 after the abort: single 1-byte block
        d0 = done_cnt;
        push(0, 0, 1, 1);
        push(1, 1, 0, 0);
        start_msg(1);
        wait_done(20, 0, "len1");
        end_msg("len1", d0);

        // maximum length: 4096 blocks, last one 15 bytes
        d0 = done_cnt;
        for (int i = 0; i < 4095; i++) push(0, 0, 0, 0);
        push(0, 0, 1, 15);
        push(1, 1, 0, 0);
        start_msg(65535);
        wait_done(5000, 0, "lenmax");
        end_msg("lenmax", d0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ascon_output_ctrl.md
Name: ascon_output_ctrl

Overview:
- Sequences the AEAD128 output stream: counts the 128-bit ciphertext/plaintext blocks for a message of a given byte length, then the tag block.
- Drives the output truncation stage's enable and pad index on the final partial block.
- Handshakes between the datapath (block source) and the downstream output interface.
- Sits between the ascon core datapath and the output truncation stage; the data bus does not pass through this block.

Parameters:
- LEN_W, 16, width of the message byte-length input (max message 2^LEN_W-1 bytes).
- BLOCK_BYTES, 16, bytes per block; must equal BLOCK_WIDTH/8 from ascon_pack.
- PAD_AW, 4, width of the truncation index; log2(BLOCK_BYTES).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  start a message; sampled only in IDLE.
- len_i  in  LEN_W  message length in bytes; sampled with start_i.
- busy_o  out  1  high in any state other than IDLE.
- blk_valid_i  in  1  datapath presents a data or tag block.
- blk_ready_o  out  1  controller accepts the current datapath block.
- out_valid_o  out  1  output block valid downstream.
- out_ready_i  in  1  downstream accepts the block.
- trunc_en_o  out  1  truncation enable for the output truncation stage.
- trunc_idx_o  out  PAD_AW  valid byte count of the final partial block.
- tag_o  out  1  current output block is the tag.
- last_o  out  1  final block of the message (the tag).
- done_o  out  1  one-cycle pulse after the tag transfer.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE, counters 0, done_o=0.
  - All combinational outputs then evaluate to 0.
  - Reset mid-message abandons the message with no done_o pulse.
- FSM has states IDLE, DATA, TAG, DONE.
- IDLE:
  - start_i=1 registers nblk = ceil(len_i/16), stored in LEN_W-3 bits, and rem = len_i[3:0].
  - It then goes to DATA if nblk>0, or to TAG if len_i=0.
- DATA:
  - blk_ready_o = out_ready_i; out_valid_o = blk_valid_i.
  - A transfer occurs when blk_valid_i & out_ready_i; each transfer decrements nblk.
  - When a transfer occurs with nblk=1, go to TAG.
- TAG:
  - Same handshake as DATA; tag_o=1, last_o=1.
  - A transfer goes to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Handshake is combinational pass-through; latency 0 cycles; no buffering.
  - out_valid_o must not depend on out_ready_i.
  - While blk_valid_i=1 and out_ready_i=0, the block is held and all control outputs stay stable.
- Truncation control:
  - trunc_en_o=1 only in DATA with nblk=1 and rem!=0.
  - trunc_idx_o = rem whenever trunc_en_o=1; otherwise 0.
  - A full final block (rem=0) is passed untruncated.
  - Tag blocks are never truncated.
- Outside DATA/TAG: out_valid_o=0, blk_ready_o=0, tag_o=0, last_o=0.
- start_i while busy is ignored; len_i is don't-care outside an IDLE start.
- Max length 2^LEN_W-1 yields nblk = 2^(LEN_W-4) with no overflow, because of the extra count bit.

Test Plan:
- len=0, always-ready sink -> exactly one transfer with tag_o=last_o=1 and trunc_en_o=0; done_o high one cycle later; busy_o falls after done_o.
- len=16 -> one data block (trunc_en_o=0), then the tag; 2 transfers total.
- len=35 -> 3 data blocks; on the 3rd, trunc_en_o=1 and trunc_idx_o=3; then the tag.
- len=32 with out_ready_i toggling 0/1 every cycle -> blk_ready_o mirrors out_ready_i; counts are unaffected by stalls; exactly 3 transfers.
- start_i pulsed with len=5 during DATA of a len=48 message -> the second start is ignored; 4 transfers, then a single done_o.
- rst_i asserted after the 1st data transfer of len=64 -> next cycle busy_o=0 and out_valid_o=0, no done_o; a new start with len=1 works (trunc_idx_o=1).
